// File: rtl/pulse_divider_bank.sv
// Bank of NUM_CH programmable clock-enable dividers with global sync realignment.
// Define PULSE_DIV_CASCADE_EN to chain channel i>0 onto the strobe of channel i-1.
module pulse_divider_bank #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 10,
  parameter logic [NUM_CH*CNT_W-1:0] TC_RST = {10'd999, 10'd99, 10'd9}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_tc,
  output logic [NUM_CH-1:0] pulse,
  output logic [7:0]        wrap_cnt
);

  logic [NUM_CH-1:0] pulse_d;
  logic [NUM_CH-1:0] advance;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] TC_INIT = TC_RST[i*CNT_W +: CNT_W];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pulse_q, pulse_n;
    logic             cfg_hit;

    // Out-of-range cfg_ch values match no channel index, so they are dropped.
    assign cfg_hit = cfg_we && (cfg_ch == 4'(i));

    always_comb begin
      cnt_d     = cnt_q;
      active_d  = active_q;
      pulse_n   = 1'b0;
      pending_d = cfg_hit ? cfg_tc : pending_q;
      if (sync) begin
        // A write landing with sync bypasses the pending stage.
        cnt_d    = '0;
        active_d = cfg_hit ? cfg_tc : pending_q;
        pulse_n  = ch_en[i];
      end else if (!ch_en[i]) begin
        cnt_d    = '0;
        active_d = pending_q;
      end else if (advance[i]) begin
        if (cnt_q == active_q) begin
          cnt_d    = '0;
          active_d = pending_q;
          pulse_n  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q     <= '0;
        active_q  <= TC_INIT;
        pending_q <= TC_INIT;
        pulse_q   <= 1'b1;
      end else begin
        cnt_q     <= cnt_d;
        active_q  <= active_d;
        pending_q <= pending_d;
        pulse_q   <= pulse_n;
      end
    end

    assign pulse[i]   = pulse_q;
    assign pulse_d[i] = pulse_n;

`ifdef PULSE_DIV_CASCADE_EN
    if (i == 0) begin : g_head
      assign advance[i] = 1'b1;
    end else begin : g_chain
      // Stalled (not cleared) whenever the upstream channel stops strobing.
      assign advance[i] = pulse[i-1];
    end
`else
    assign advance[i] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt <= 8'd0;
    end else if (pulse_d[0]) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pulse_divider_bank.sv
// Directed + randomized bench for pulse_divider_bank (default, non-cascade build).
module tb_pulse_divider_bank;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              sync;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_tc;
  logic [NUM_CH-1:0] pulse;
  logic [7:0]        wrap_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles remaining until each channel's next strobe.
  int tc_rst [NUM_CH] = '{9, 99, 999};
  int m_left [NUM_CH];
  int m_act  [NUM_CH];
  int m_pend [NUM_CH];
  logic [NUM_CH-1:0] m_pulse;
  int m_wrap;

  pulse_divider_bank dut (
    .clk(clk), .rst(rst), .sync(sync), .ch_en(ch_en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tc(cfg_tc),
    .pulse(pulse), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_act[i]  = tc_rst[i];
        m_pend[i] = tc_rst[i];
        m_left[i] = tc_rst[i] + 1;
        m_pulse[i] = 1'b1;
      end
      m_wrap = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        bit hit;
        hit = cfg_we && (int'(cfg_ch) == i);
        if (sync) begin
          m_act[i]   = hit ? int'(cfg_tc) : m_pend[i];
          m_left[i]  = m_act[i] + 1;
          m_pulse[i] = ch_en[i];
        end else if (!ch_en[i]) begin
          m_act[i]   = m_pend[i];
          m_left[i]  = m_pend[i] + 1;
          m_pulse[i] = 1'b0;
        end else begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_pulse[i] = 1'b1;
            m_act[i]   = m_pend[i];
            m_left[i]  = m_act[i] + 1;
          end else begin
            m_pulse[i] = 1'b0;
          end
        end
        if (hit) m_pend[i] = int'(cfg_tc);
      end
      if (m_pulse[0]) m_wrap = (m_wrap + 1) % 256;
    end
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (pulse === m_pulse) else begin
      miscompares++;
      $error("FAIL %s pulse: observed %b expected %b at %0t", tag, pulse, m_pulse, $time);
    end
    vectors++;
    assert (wrap_cnt === 8'(m_wrap)) else begin
      miscompares++;
      $error("FAIL %s wrap_cnt: observed %0d expected %0d at %0t", tag, wrap_cnt, m_wrap, $time);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic write_tc(input int ch, input int tc, input string tag);
    cfg_we = 1'b1;
    cfg_ch = 4'(ch);
    cfg_tc = CNT_W'(tc);
    step(tag);
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; ch_en = '1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_tc = '0;
    run(2, "reset");
    write_tc(0, 2, "reset_write_ignored");
    rst = 1'b0;

    run(1000, "defaults");
    vectors++;
    assert (wrap_cnt === 8'd100) else begin
      miscompares++;
      $error("FAIL wrap_after_1000: observed %0d expected 100", wrap_cnt);
    end

    run(3, "pre_reprogram");
    write_tc(0, 4, "reprogram_ch0");
    run(30, "reprogram_ch0");
    write_tc(5, 1, "write_ch5");
    run(20, "write_ch5");

    write_tc(1, 0, "tc0_ch1");
    run(120, "tc0_ch1");
    ch_en[1] = 1'b0;
    run(5, "ch1_disabled");
    ch_en[1] = 1'b1;
    run(10, "ch1_reenabled");

    sync = 1'b1;
    write_tc(2, 49, "sync_write");
    sync = 1'b0;
    run(120, "after_sync");

    run(7, "pre_mid_reset");
    rst = 1'b1;
    run(2, "mid_reset");
    rst = 1'b0;
    run(30, "after_mid_reset");

    for (int k = 0; k < 2000; k++) begin
      rst    = ($urandom_range(0, 199) == 0);
      sync   = ($urandom_range(0, 49) == 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_ch = 4'($urandom_range(0, 7));
      cfg_tc = CNT_W'($urandom_range(0, 20));
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 29) == 0) ch_en[i] = ~ch_en[i];
      step("random");
    end
    rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
